button_conditioner: RTL and testbench

//  Upstream input stage for connect_four_top: turns three raw, asynchronous, bouncing push-buttons

---
 rtl/button_pkg.sv | 33 +++
 rtl/debounce_channel.sv | 52 +++++
 rtl/button_conditioner.sv | 148 ++++++++++++++
 tb/tb_button_conditioner.sv | 145 ++++++++++++++
 4 files changed

// File: rtl/button_pkg.sv
`default_nettype none
// ============================================================================
// Module   : button_pkg
// Brief    : Shared types, default timing constants and channel indices for
//            the push-button conditioning front end.
// Revision : 1.0 - initial release
// ============================================================================
package button_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        HOLD_WAIT = 2'd1,
        REPEAT    = 2'd2
    } rpt_state_t;

    // Defaults assume the 25 MHz pixel clock: 10 ms, 500 ms, 125 ms.
    localparam int DEF_DEBOUNCE_CYCLES = 250000;
    localparam int DEF_REPEAT_DELAY    = 12500000;
    localparam int DEF_REPEAT_RATE     = 3125000;
    localparam int DEF_CNT_W           = 24;

    localparam int BTN_LEFT  = 0;
    localparam int BTN_RIGHT = 1;
    localparam int BTN_DROP  = 2;
    localparam int NUM_BTN   = 3;

    // True when a counter of the given width can reach cycles-1 without wrapping.
    function automatic bit cnt_fits(input int cycles, input int width);
        return (longint'(cycles) - longint'(1)) < (longint'(1) <<< width);
    endfunction

endpackage
`default_nettype wire

// File: rtl/debounce_channel.sv
`default_nettype none
// ============================================================================
// Module   : debounce_channel
// Brief    : Two-flop synchroniser, counter debouncer and rising-edge detect
//            for one raw push-button.
// Revision : 1.0 - initial release
// ============================================================================
module debounce_channel #(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int CNT_W           = 24
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic lvl,
    output logic press
);

    logic             r_s1;
    logic             r_s2;
    logic             r_lvl;
    logic             r_lvl_d;
    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1    <= 1'b0;
            r_s2    <= 1'b0;
            r_lvl   <= 1'b0;
            r_lvl_d <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_s1    <= raw;
            r_s2    <= r_s1;
            r_lvl_d <= r_lvl;
            // Any return to the accepted level wipes the count: no partial credit.
            if (r_s2 == r_lvl) begin
                r_cnt <= '0;
            end else if (r_cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                r_lvl <= r_s2;
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    assign lvl   = r_lvl;
    assign press = r_lvl & ~r_lvl_d;

endmodule
`default_nettype wire

// File: rtl/button_conditioner.sv
`default_nettype none
// ============================================================================
// Module   : button_conditioner
// Brief    : Turns three raw bouncing buttons into clean one-cycle game
//            strobes, with hold-to-repeat on left/right and drop priority.
// Revision : 1.0 - initial release
// ============================================================================
module button_conditioner
    import button_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int REPEAT_RATE     = DEF_REPEAT_RATE,
    parameter int CNT_W           = DEF_CNT_W
) (
    input  logic       clk_25MHz,
    input  logic       rst,
    input  logic       btn_left_raw,
    input  logic       btn_right_raw,
    input  logic       btn_drop_raw,
    input  logic       enable,
    output logic       move_left,
    output logic       move_right,
    output logic       drop_piece,
    output logic [2:0] btn_level
);

    if (!cnt_fits(DEBOUNCE_CYCLES, CNT_W) || !cnt_fits(REPEAT_DELAY, CNT_W) ||
        !cnt_fits(REPEAT_RATE, CNT_W)) begin : g_cnt_w_check
        $error("button_conditioner: CNT_W too narrow for timing parameters");
    end

    logic [NUM_BTN-1:0] w_raw;
    logic [NUM_BTN-1:0] w_lvl;
    logic [NUM_BTN-1:0] w_press;
    logic [1:0]         w_move_fire;
    logic               w_conflict;
    logic               w_drop_fire;
    logic               r_move_left;
    logic               r_move_right;
    logic               r_drop_piece;

    assign w_raw = {btn_drop_raw, btn_right_raw, btn_left_raw};

    for (genvar g = 0; g < NUM_BTN; g++) begin : g_chan
        debounce_channel #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .CNT_W           (CNT_W)
        ) u_debounce (
            .clk   (clk_25MHz),
            .rst   (rst),
            .raw   (w_raw[g]),
            .lvl   (w_lvl[g]),
            .press (w_press[g])
        );
    end

    assign w_conflict  = w_lvl[BTN_LEFT] & w_lvl[BTN_RIGHT];
    assign w_drop_fire = enable & w_press[BTN_DROP];

    for (genvar g = 0; g < 2; g++) begin : g_repeat
        rpt_state_t       r_state;
        rpt_state_t       w_state_nxt;
        logic [CNT_W-1:0] r_rt;
        logic [CNT_W-1:0] w_rt_nxt;
        logic             w_fire;

        always_ff @(posedge clk_25MHz) begin
            if (rst) begin
                r_state <= IDLE;
                r_rt    <= '0;
            end else begin
                r_state <= w_state_nxt;
                r_rt    <= w_rt_nxt;
            end
        end

        always_comb begin
            w_state_nxt = r_state;
            w_rt_nxt    = r_rt;
            w_fire      = 1'b0;
            // Both directions held cancels any press; a fresh press is required afterwards.
            if (!enable || w_conflict) begin
                w_state_nxt = IDLE;
                w_rt_nxt    = '0;
            end else begin
                case (r_state)
                    IDLE: begin
                        w_rt_nxt = '0;
                        if (w_press[g]) begin
                            w_fire      = 1'b1;
                            w_state_nxt = HOLD_WAIT;
                        end
                    end
                    HOLD_WAIT: begin
                        if (!w_lvl[g]) begin
                            w_state_nxt = IDLE;
                            w_rt_nxt    = '0;
                        end else if (r_rt == CNT_W'(REPEAT_DELAY - 1)) begin
                            w_fire      = 1'b1;
                            w_state_nxt = REPEAT;
                            w_rt_nxt    = '0;
                        end else begin
                            w_rt_nxt = r_rt + CNT_W'(1);
                        end
                    end
                    REPEAT: begin
                        if (!w_lvl[g]) begin
                            w_state_nxt = IDLE;
                            w_rt_nxt    = '0;
                        end else if (r_rt == CNT_W'(REPEAT_RATE - 1)) begin
                            w_fire   = 1'b1;
                            w_rt_nxt = '0;
                        end else begin
                            w_rt_nxt = r_rt + CNT_W'(1);
                        end
                    end
                    default: begin
                        w_state_nxt = IDLE;
                        w_rt_nxt    = '0;
                    end
                endcase
            end
        end

        assign w_move_fire[g] = w_fire;
    end

    // A drop strobe masks any coincident move strobe; the move timers keep running.
    always_ff @(posedge clk_25MHz) begin
        if (rst) begin
            r_move_left  <= 1'b0;
            r_move_right <= 1'b0;
            r_drop_piece <= 1'b0;
        end else begin
            r_move_left  <= w_move_fire[BTN_LEFT]  & ~w_drop_fire;
            r_move_right <= w_move_fire[BTN_RIGHT] & ~w_drop_fire;
            r_drop_piece <= w_drop_fire;
        end
    end

    assign move_left  = r_move_left;
    assign move_right = r_move_right;
    assign drop_piece = r_drop_piece;
    assign btn_level  = w_lvl;

endmodule
`default_nettype wire

// File: tb/tb_button_conditioner.sv
`default_nettype none
// ============================================================================
// Module   : tb_button_conditioner
// Brief    : Directed self-checking bench for button_conditioner with short
//            timing (debounce 4, repeat delay 10, repeat rate 3).
// Revision : 1.0 - initial release
// ============================================================================
module tb_button_conditioner;

    logic       clk_25MHz = 1'b0;
    logic       rst;
    logic       btn_left_raw;
    logic       btn_right_raw;
    logic       btn_drop_raw;
    logic       enable;
    logic       move_left;
    logic       move_right;
    logic       drop_piece;
    logic [2:0] btn_level;
    logic [2:0] strb;

    int checks = 0;
    int errors = 0;

    always #20 clk_25MHz = ~clk_25MHz;

    assign strb = {drop_piece, move_right, move_left};

    button_conditioner #(
        .DEBOUNCE_CYCLES (4),
        .REPEAT_DELAY    (10),
        .REPEAT_RATE     (3),
        .CNT_W           (8)
    ) dut (
        .clk_25MHz     (clk_25MHz),
        .rst           (rst),
        .btn_left_raw  (btn_left_raw),
        .btn_right_raw (btn_right_raw),
        .btn_drop_raw  (btn_drop_raw),
        .enable        (enable),
        .move_left     (move_left),
        .move_right    (move_right),
        .drop_piece    (drop_piece),
        .btn_level     (btn_level)
    );

    task automatic chk(input string tag, input int cyc, input logic [2:0] obs,
                       input logic [2:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s cycle %0d observed %b expected %b", tag, cyc, obs, exp);
        end
    endtask

    // Cycle k of each step starts at the k-th negedge: inputs for that cycle
    // are applied there, and outputs registered at the preceding posedge are checked.
    initial begin
        rst           = 1'b1;
        btn_left_raw  = 1'b0;
        btn_right_raw = 1'b0;
        btn_drop_raw  = 1'b0;
        enable        = 1'b1;
        repeat (3) @(negedge clk_25MHz);
        chk("reset_strobes", 0, strb, 3'b000);
        chk("reset_level", 0, btn_level, 3'b000);
        rst = 1'b0;
        repeat (2) @(negedge clk_25MHz);

        // Single clean press, released after 6 cycles.
        for (int k = 0; k < 20; k++) begin
            btn_left_raw = (k < 6);
            chk("t1_strobe", k, strb, (k == 7) ? 3'b001 : 3'b000);
            if (k == 5)  chk("t1_level_before", k, btn_level, 3'b000);
            if (k == 6)  chk("t1_level_set", k, btn_level, 3'b001);
            if (k == 11) chk("t1_level_hold", k, btn_level, 3'b001);
            if (k == 12) chk("t1_level_clear", k, btn_level, 3'b000);
            @(negedge clk_25MHz);
        end

        // Bouncing right button, final rise at cycle 8.
        for (int k = 0; k < 30; k++) begin
            btn_right_raw = (k < 8) ? (((k / 2) % 2) == 0) : (k < 16);
            chk("t2_strobe", k, strb, (k == 15) ? 3'b010 : 3'b000);
            if (k == 13) chk("t2_level_before", k, btn_level, 3'b000);
            if (k == 14) chk("t2_level_set", k, btn_level, 3'b010);
            @(negedge clk_25MHz);
        end

        // Hold-to-repeat: first strobe 7, repeat at 17 then every 3 until release settles.
        for (int k = 0; k < 64; k++) begin
            btn_left_raw = (k < 47);
            chk("t3_strobe", k, strb,
                (k == 7 || (k >= 17 && k <= 53 && ((k - 17) % 3) == 0)) ? 3'b001 : 3'b000);
            if (k == 52) chk("t3_level_hold", k, btn_level, 3'b001);
            if (k == 53) chk("t3_level_clear", k, btn_level, 3'b000);
            @(negedge clk_25MHz);
        end

        // Left held, right pressed then released, left re-pressed.
        for (int k = 0; k < 80; k++) begin
            btn_left_raw  = (k < 50) || (k >= 60 && k < 68);
            btn_right_raw = (k >= 8 && k < 20);
            chk("t4_strobe", k, strb, (k == 7 || k == 67) ? 3'b001 : 3'b000);
            if (k == 14) chk("t4_level_both", k, btn_level, 3'b011);
            if (k == 26) chk("t4_level_left", k, btn_level, 3'b001);
            @(negedge clk_25MHz);
        end

        // Drop and left together: drop wins, left timer still reaches its repeat.
        for (int k = 0; k < 30; k++) begin
            btn_left_raw = (k < 12);
            btn_drop_raw = (k < 12);
            chk("t5_strobe", k, strb,
                (k == 7) ? 3'b100 : ((k == 17) ? 3'b001 : 3'b000));
            if (k == 6) chk("t5_level", k, btn_level, 3'b101);
            @(negedge clk_25MHz);
        end

        // Press while disabled, then held through re-enable.
        for (int k = 0; k < 30; k++) begin
            enable       = (k >= 10);
            btn_left_raw = (k < 20);
            btn_drop_raw = (k < 20);
            chk("t6_disabled_strobe", k, strb, 3'b000);
            if (k == 8) chk("t6_level_disabled", k, btn_level, 3'b101);
            @(negedge clk_25MHz);
        end

        // Reset in the middle of HOLD_WAIT with the button still held briefly after.
        for (int k = 0; k < 30; k++) begin
            btn_left_raw = (k < 14);
            rst          = (k == 10 || k == 11);
            chk("t6_reset_strobe", k, strb, (k == 7) ? 3'b001 : 3'b000);
            if (k == 9)  chk("t6_level_pre_rst", k, btn_level, 3'b001);
            if (k == 12) chk("t6_level_post_rst", k, btn_level, 3'b000);
            @(negedge clk_25MHz);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
